// File: rtl/cpu32_pkg.sv
// rtl/cpu32_pkg.sv - shared cpu32 types used by the memory arbiter
//
// Purpose : enumerations for the arbiter sequencer state and the
//           identity of the port that currently owns the RAM.
// Contents: arb_state_t {ARB_IDLE, ARB_BUSY}
//           arb_owner_t {OWN_I, OWN_D}
package cpu32_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data/RAM signal bundle around mem_arbiter
//
// Purpose : groups the instruction-fetch port, the load/store port and the
//           single-port RAM port that the arbiter sits between.
// Modports:
//   slave  - the arbiter: takes requests and RAM read data, drives acks,
//            read data, stalls and the RAM strobe/address/write data.
//   master - the surroundings (pipeline plus RAM): the mirror image.
interface mem_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
) ();

    // instruction-fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          i_stall;

    // load/store port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          d_stall;

    // single-port RAM
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata, i_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata, i_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - one-at-a-time arbiter sharing a single-port RAM
//
// Purpose : shares one synchronous single-port RAM between the fetch port and
//           the load/store port. Each access is granted, issued for one cycle,
//           held while the RAM read latency elapses, then acknowledged. Data
//           wins ties; a saturating starvation counter forces a fetch grant
//           after STARVE_MAX consecutive data grants with a fetch pending.
// Params  : AW (word-address width), DW (data width),
//           RD_LAT (RAM read latency, 1..4), STARVE_MAX (data grants allowed
//           while a fetch waits).
// Ports   : clk     - sole clock, rising edge
//           reset_n - asynchronous assert, synchronous release, active low
//           bus     - mem_arbiter_if.slave: fetch port (i_*), load/store port
//                     (d_*), RAM port (mem_*)
module mem_arbiter
    import cpu32_pkg::*;
#(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    // Counter widths; both are kept at least one bit wide.
    localparam int CW = (RD_LAT < 1)     ? 1 : $clog2(RD_LAT + 1);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // A read waits RD_LAT-1 BUSY cycles before the ack cycle; a write acks
    // in the first BUSY cycle.
    localparam logic [CW-1:0] RD_CNT_INIT = CW'(RD_LAT - 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    arb_state_t    state,  state_nxt;
    arb_owner_t    owner,  owner_nxt;
    logic          is_wr,  is_wr_nxt;
    logic [CW-1:0] cnt,    cnt_nxt;
    logic [SW-1:0] starve, starve_nxt;

    // ------------------------------------------------------------------
    // winner pick (only meaningful while IDLE with a request present)
    // ------------------------------------------------------------------
    logic any_req;
    logic pick_d;

    always_comb begin
        any_req = bus.i_req | bus.d_req;
        // Data wins unless a fetch has watched STARVE_MAX data grants go by.
        pick_d  = bus.d_req & ~(bus.i_req & (starve == STARVE_SAT));
    end

    // ------------------------------------------------------------------
    // next-state and raw outputs
    // ------------------------------------------------------------------
    logic          issue;
    logic          mem_en_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;
    logic          i_ack_c;
    logic          d_ack_c;
    logic [DW-1:0] rdata_c;

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        is_wr_nxt   = is_wr;
        cnt_nxt     = cnt;
        issue       = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        i_ack_c     = 1'b0;
        d_ack_c     = 1'b0;
        rdata_c     = '0;

        unique case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    issue    = 1'b1;
                    mem_en_c = 1'b1;
                    if (pick_d) begin
                        mem_we_c    = bus.d_we;
                        mem_addr_c  = bus.d_addr;
                        mem_wdata_c = bus.d_wdata;
                        owner_nxt   = OWN_D;
                        is_wr_nxt   = bus.d_we;
                        cnt_nxt     = bus.d_we ? '0 : RD_CNT_INIT;
                    end else begin
                        // fetches are always reads
                        mem_addr_c  = bus.i_addr;
                        owner_nxt   = OWN_I;
                        is_wr_nxt   = 1'b0;
                        cnt_nxt     = RD_CNT_INIT;
                    end
                    state_nxt = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    // RAM data lands in this very cycle; pass it straight
                    // through instead of registering it.
                    if (owner == OWN_D) begin
                        d_ack_c = 1'b1;
                    end else begin
                        i_ack_c = 1'b1;
                    end
                    rdata_c   = is_wr ? '0 : bus.mem_rdata;
                    state_nxt = ARB_IDLE;
                end
            end

            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // starvation guard
    // ------------------------------------------------------------------
    always_comb begin
        starve_nxt = starve;
        if (!bus.i_req || (issue && !pick_d)) begin
            starve_nxt = '0;
        end else if (issue && pick_d && (starve != STARVE_SAT)) begin
            starve_nxt = starve + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ARB_IDLE;
            owner  <= OWN_D;
            is_wr  <= 1'b0;
            cnt    <= '0;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            is_wr  <= is_wr_nxt;
            cnt    <= cnt_nxt;
            starve <= starve_nxt;
        end
    end

    // ------------------------------------------------------------------
    // outputs
    // ------------------------------------------------------------------
    // The issue path is combinational from the requests, so every output is
    // also qualified by reset_n to keep them all quiet while reset is held.
    assign bus.mem_en    = reset_n & mem_en_c;
    assign bus.mem_we    = reset_n & mem_we_c;
    assign bus.mem_addr  = reset_n ? mem_addr_c  : '0;
    assign bus.mem_wdata = reset_n ? mem_wdata_c : '0;

    assign bus.i_ack     = reset_n & i_ack_c;
    assign bus.d_ack     = reset_n & d_ack_c;
    assign bus.i_rdata   = (reset_n && i_ack_c) ? rdata_c : '0;
    assign bus.d_rdata   = (reset_n && d_ack_c) ? rdata_c : '0;

    // Stalls drop in the ack cycle so the pipeline advances on that edge.
    assign bus.i_stall   = reset_n & bus.i_req & ~i_ack_c;
    assign bus.d_stall   = reset_n & bus.d_req & ~d_ack_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    localparam int AW         = 30;
    localparam int DW         = 32;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int k);
        return 32'hA5000000 ^ (32'(k) * 32'h00010203);
    endfunction

    // ---------------- RAM environment (RD_LAT pipeline) ----------------
    logic [DW-1:0] ram [256];
    logic [DW-1:0] rd_pipe [RD_LAT];
    logic          ram_init = 1'b0;
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int k = 0; k < 256; k++) ram[k] <= init_word(k);
            ram_init <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr[7:0]] : 32'hBAD0BAD0;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    // ---------------- reference model ----------------
    typedef struct {
        bit            is_d;
        longint        cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    longint        cyc = 0;
    longint        free_at = 0;
    int            m_starve = 0;
    logic [DW-1:0] shadow [256];
    bit            sh_init = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level view: the RAM is free from free_at onwards; when free
    // and anyone asks, the priority rule names the winner and an expected ack
    // (port, cycle, data) is queued.
    always @(negedge clk) begin : model
        bit            gd;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        int            lat;
        exp_t          e;
        if (!sh_init) begin
            for (int k = 0; k < 256; k++) shadow[k] = init_word(k);
            sh_init = 1;
        end
        if (!reset_n) begin
            chk_eq("rst_ctl", 64'({bus.mem_en, bus.mem_we, bus.i_ack, bus.d_ack, bus.i_stall, bus.d_stall}), 64'd0);
            chk_eq("rst_bus", 64'({bus.mem_addr, bus.mem_wdata}), 64'd0);
            chk_eq("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
            exp_q.delete();
            m_starve = 0;
            free_at  = cyc + 1;
        end else begin
            if (cyc >= free_at && (bus.i_req || bus.d_req)) begin
                gd  = bus.d_req && !(bus.i_req && m_starve == STARVE_MAX);
                ew  = gd ? bus.d_we : 1'b0;
                ea  = gd ? bus.d_addr : bus.i_addr;
                ewd = gd ? bus.d_wdata : '0;
                chk_eq("issue_en", 64'(bus.mem_en), 64'd1);
                chk_eq("issue_we", 64'(bus.mem_we), 64'(ew));
                chk_eq("issue_addr", 64'(bus.mem_addr), 64'(ea));
                chk_eq("issue_wdata", 64'(bus.mem_wdata), 64'(ewd));
                lat    = ew ? 1 : RD_LAT;
                e.is_d = gd;
                e.cyc  = cyc + lat;
                e.data = ew ? '0 : shadow[ea[7:0]];
                exp_q.push_back(e);
                if (ew) shadow[ea[7:0]] = ewd;
                free_at = cyc + lat + 1;
                if (!bus.i_req || !gd) m_starve = 0;
                else if (m_starve < STARVE_MAX) m_starve++;
            end else begin
                chk_eq("idle_bus", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'd0);
                if (!bus.i_req) m_starve = 0;
            end
            chk_eq("i_stall", 64'(bus.i_stall), 64'(bus.i_req & ~bus.i_ack));
            chk_eq("d_stall", 64'(bus.d_stall), 64'(bus.d_req & ~bus.d_ack));
            if (!bus.i_ack) chk_eq("i_rdata_idle", 64'(bus.i_rdata), 64'd0);
            if (!bus.d_ack) chk_eq("d_rdata_idle", 64'(bus.d_rdata), 64'd0);
        end
    end

    // ---------------- monitor ----------------
    bit     log_en = 0;
    bit     ack_log[$];
    bit     wait_en = 0;
    int     dwait = 0;
    int     max_dwait = 0;

    always @(negedge clk) begin : monitor
        bit   exp_now;
        exp_t e;
        if (reset_n) begin
            exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk_eq("ack_present", 64'(bus.i_ack | bus.d_ack), 64'(exp_now));
            chk_eq("ack_exclusive", 64'(bus.i_ack & bus.d_ack), 64'd0);
            chk_eq("no_issue_in_ack", 64'(bus.mem_en & (bus.i_ack | bus.d_ack)), 64'd0);
            if (exp_now) begin
                e = exp_q.pop_front();
                chk_eq("ack_port", 64'({bus.i_ack, bus.d_ack}), e.is_d ? 64'd1 : 64'd2);
                chk_eq("ack_rdata", 64'(e.is_d ? bus.d_rdata : bus.i_rdata), 64'(e.data));
            end
            if (log_en && (bus.i_ack || bus.d_ack)) ack_log.push_back(bus.d_ack);
            // fetch addresses sit at 0x80+ while this tracking is enabled
            if (wait_en && bus.mem_en && bus.i_req) begin
                if (bus.mem_addr[7]) begin
                    if (dwait > max_dwait) max_dwait = dwait;
                    dwait = 0;
                end else begin
                    dwait++;
                end
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic i_access(input logic [AW-1:0] a, output logic [DW-1:0] rd, output int lat);
        int n = 0;
        bus.i_req  = 1'b1;
        bus.i_addr = a;
        rd = '0;
        @(negedge clk);
        while (!bus.i_ack && n < 200) begin n++; @(negedge clk); end
        chk_eq("i_ack_seen", 64'(bus.i_ack), 64'd1);
        rd  = bus.i_rdata;
        lat = n;
        @(posedge clk); #1;
        bus.i_req  = 1'b0;
        bus.i_addr = '0;
    endtask

    task automatic d_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                            output logic [DW-1:0] rd, output int lat);
        int n = 0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        rd = '0;
        @(negedge clk);
        while (!bus.d_ack && n < 200) begin n++; @(negedge clk); end
        chk_eq("d_ack_seen", 64'(bus.d_ack), 64'd1);
        rd  = bus.d_rdata;
        lat = n;
        @(posedge clk); #1;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] rd_i, rd_d;
        int            lat_i, lat_d;
        logic [9:0]    seq;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        idle(2);

        // single fetch
        i_access(30'h10, rd_i, lat_i);
        chk_eq("fetch_data", 64'(rd_i), 64'(init_word(16)));
        chk_eq("fetch_lat", 64'(lat_i), 64'(RD_LAT));
        idle(2);

        // store then load of the same word
        d_access(1'b1, 30'h20, 32'hDEADBEEF, rd_d, lat_d);
        chk_eq("store_lat", 64'(lat_d), 64'd1);
        d_access(1'b0, 30'h20, 32'h0, rd_d, lat_d);
        chk_eq("load_data", 64'(rd_d), 64'hDEADBEEF);
        chk_eq("load_lat", 64'(lat_d), 64'(RD_LAT));
        idle(3);

        // both ports requesting continuously: grant order D,D,D,D,I,D,D,D,D,I
        ack_log.delete();
        log_en = 1; wait_en = 1; dwait = 0; max_dwait = 0;
        fork
            begin
                logic [DW-1:0] r; int l;
                repeat (2) i_access(AW'(8'h80 + 8'($urandom_range(0, 15))), r, l);
            end
            begin
                logic [DW-1:0] r; int l;
                repeat (8) d_access(1'b0, AW'($urandom_range(0, 63)), $urandom, r, l);
            end
        join
        log_en = 0;
        seq = '0;
        for (int k = 0; k < 10 && k < ack_log.size(); k++) seq[9-k] = ack_log[k];
        chk_eq("grant_count", 64'(ack_log.size()), 64'd10);
        chk_eq("grant_order", 64'(seq), 64'(10'b1111011110));
        chk_eq("starve_wait", 64'(max_dwait), 64'(STARVE_MAX));
        idle(3);

        // data stream with no fetch, then a fetch arrives mid-stream
        dwait = 0; max_dwait = 0;
        fork
            begin
                logic [DW-1:0] r; int l;
                repeat (12) d_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom, r, l);
            end
            begin
                logic [DW-1:0] r; int l;
                idle(9);
                i_access(30'h90, r, l);
                chk_eq("late_fetch_data", 64'(r), 64'(init_word(8'h90)));
            end
        join
        wait_en = 0;
        chk_eq("late_fetch_bound", 64'(max_dwait <= STARVE_MAX), 64'd1);
        idle(3);

        // reset pulsed in cycle 1 of a read: the old read must never ack
        fork
            begin
                logic [DW-1:0] r; int l;
                i_access(30'h33, r, l);
                chk_eq("post_reset_data", 64'(r), 64'(init_word(8'h33)));
            end
            begin
                @(negedge clk);
                chk_eq("rst_issue_seen", 64'(bus.mem_en), 64'd1);
                @(posedge clk); #3;
                reset_n = 1'b0;
                @(posedge clk); #1;
                reset_n = 1'b1;
            end
        join
        idle(3);

        // random traffic on both ports
        fork
            begin
                logic [DW-1:0] r; int l;
                repeat (30) begin
                    i_access(AW'($urandom_range(0, 15)), r, l);
                    idle($urandom_range(0, 3));
                end
            end
            begin
                logic [DW-1:0] r; int l;
                repeat (30) begin
                    d_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, r, l);
                    idle($urandom_range(0, 3));
                end
            end
        join
        idle(5);
        chk_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous RAM between the instruction-fetch port and the load/store data port of the cpu32 core. It sequences one access at a time: grant, issue, wait for the read latency, acknowledge. It drives per-port stall signals that the pipeline ORs into the decode `hazard` input. Data accesses have priority, and a starvation guard guarantees instruction fetch forward progress.

## Interface
Parameters:
- `AW`, 30, word-address width.
- `DW`, 32, data width.
- `RD_LAT`, 1, RAM read latency in cycles, legal range 1..4.
- `STARVE_MAX`, 4, consecutive data grants allowed while a fetch is pending.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held with `i_addr` until `i_ack`.
- `i_addr`  in  AW  fetch word address.
- `i_ack`  out  1  one-cycle pulse: fetch complete, `i_rdata` valid.
- `i_rdata`  out  DW  fetch data, valid only with `i_ack`.
- `i_stall`  out  1  `i_req & ~i_ack`.
- `d_req`  in  1  data request; held with `d_we/d_addr/d_wdata` until `d_ack`.
- `d_we`  in  1  1=store, 0=load.
- `d_addr`  in  AW  data word address.
- `d_wdata`  in  DW  store data.
- `d_ack`  out  1  one-cycle pulse: access complete; `d_rdata` valid on loads.
- `d_rdata`  out  DW  load data, valid only with `d_ack` for a load.
- `d_stall`  out  1  `d_req & ~d_ack`.
- `mem_en`  out  1  RAM access strobe, one cycle per access.
- `mem_we`  out  1  RAM write enable, qualified by `mem_en`.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM read data, valid exactly `RD_LAT` cycles after a read strobe.

## Operation
- States: IDLE, BUSY. Registers: `state`, `owner` (I/D), `is_wr`, `cnt` (width clog2(RD_LAT+1)), `starve` (width clog2(STARVE_MAX+1), saturating).
- IDLE, no request: `mem_en`=0; stay in IDLE.
- IDLE, any request:
  - Pick a winner combinationally.
  - D wins when `d_req`, unless `i_req` and `starve==STARVE_MAX`; then I wins.
  - I wins when only `i_req` is asserted.
  - Same cycle: `mem_en`=1, and `mem_we/mem_addr/mem_wdata` come from the winner. Fetch is always a read.
  - Next state BUSY. Latch `owner` and `is_wr`. Set `cnt` = 0 for a write, `RD_LAT-1` for a read.
- BUSY with `cnt`!=0: decrement `cnt`; no outputs.
- BUSY with `cnt`==0:
  - Pulse the owner's ack. For reads, pass `mem_rdata` straight through to the owner's rdata.
  - Next state IDLE.
  - No new issue in this cycle.
- Starve counter:
  - Increments on a D grant while `i_req`=1.
  - Clears on an I grant, or in any cycle with `i_req`=0.
  - Saturates at `STARVE_MAX`.
- Non-owner ack is always 0; rdata outputs are 0 when their ack is low.
- Requester drops its req before ack (protocol violation): the access still completes and the ack still pulses. There is no abort.
- `mem_addr/mem_wdata/mem_we` are 0 whenever `mem_en`=0.

## Timing
- Reset (async assert, sync release): state IDLE, `cnt`=0, `starve`=0, `owner`=D. All outputs 0.
- Reset mid-access: the in-flight read is discarded; no ack is issued after release.
- Read: issue at cycle 0, ack at cycle `RD_LAT`, next issue no earlier than cycle `RD_LAT+1`.
- Write: issue at cycle 0, ack at cycle 1, next issue at cycle 2.
- Stalls are combinational from req and ack, so a stall drops in the ack cycle.
- Simultaneous `i_req`/`d_req`: resolved by the priority rule above.

## Structure
- The shared package `cpu32_pkg` holds the enums `arb_state_t` {ARB_IDLE, ARB_BUSY} and `arb_owner_t` {OWN_I, OWN_D}.
- Single module; no sub-module. The winner pick is a small combinational block inside it.

## Test plan
- Reset, then one fetch to 0x10 with `RD_LAT`=2: `mem_en` at cycle 0 with `mem_addr`=0x10, `i_ack` at cycle 2 with `i_rdata`=RAM[0x10], `i_stall` high for cycles 0–1.
- Store 0xDEADBEEF to 0x20, then a load from 0x20: `d_ack` at cycle 1, load issued at cycle 2, `d_rdata`=0xDEADBEEF at cycle 2+`RD_LAT`.
- `i_req` and `d_req` both high continuously with `STARVE_MAX`=4, all loads: grant order D,D,D,D,I,D,D,D,D,I.
- `i_req` low while D streams 10 accesses: `starve` stays 0; a later `i_req` waits at most 4 D grants.
- `reset_n` pulsed low mid-read (`RD_LAT`=3, at cycle 1): no ack at cycle 3; all outputs 0; IDLE after release.
- `RD_LAT`=1 back-to-back fetches: one access every 2 cycles; `mem_en` never high in an ack cycle.
